// File: rtl/seq_alu.sv
// ============================================================================
// Module  : seq_alu
// Purpose : Multi-cycle ALU feeding the accumulator: PASS_B/ADD/SUB in one
//           cycle, unsigned shift-add MUL over WORD_SIZE cycles.
//           Optional macro SEQ_ALU_MUL_SAT_EN saturates MUL overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
  parameter int WORD_SIZE = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WORD_SIZE-1:0] a_in,
  input  logic [WORD_SIZE-1:0] b_in,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic                 alu_to_ac,
  output logic                 busy,
  output logic                 zero
);

  localparam int CNT_W = $clog2(WORD_SIZE + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);

  logic [1:0]             state_q,     state_d;
  logic [2*WORD_SIZE-1:0] mcand_q,     mcand_d;
  logic [WORD_SIZE-1:0]   mplier_q,    mplier_d;
  logic [2*WORD_SIZE-1:0] prod_q,      prod_d;
  logic [CNT_W-1:0]       count_q,     count_d;
  logic [WORD_SIZE-1:0]   alu_out_q,   alu_out_d;
  logic                   alu_to_ac_q, alu_to_ac_d;
  logic                   zero_q,      zero_d;

  logic [WORD_SIZE-1:0]   single_res;
  logic [WORD_SIZE-1:0]   mul_res;

  // Single-cycle result; carries and borrows fall off the top.
  always_comb begin
    single_res = b_in;
    case (op)
      OP_PASS: single_res = b_in;
      OP_ADD:  single_res = a_in + b_in;
      OP_SUB:  single_res = a_in - b_in;
      default: single_res = b_in;
    endcase
  end

  always_comb begin
`ifdef SEQ_ALU_MUL_SAT_EN
    if (|prod_q[2*WORD_SIZE-1:WORD_SIZE]) begin
      mul_res = {WORD_SIZE{1'b1}};
    end else begin
      mul_res = prod_q[WORD_SIZE-1:0];
    end
`else
    mul_res = prod_q[WORD_SIZE-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    count_d     = count_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    alu_to_ac_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d  = ST_MUL;
            count_d  = '0;
            prod_d   = '0;
            mcand_d  = {{WORD_SIZE{1'b0}}, a_in};
            mplier_d = b_in;
          end else begin
            alu_out_d   = single_res;
            zero_d      = (single_res == '0);
            alu_to_ac_d = 1'b1;
          end
        end
      end

      ST_MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        alu_out_d   = mul_res;
        zero_d      = (mul_res == '0);
        alu_to_ac_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      count_q     <= '0;
      alu_out_q   <= '0;
      alu_to_ac_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      count_q     <= count_d;
      alu_out_q   <= alu_out_d;
      alu_to_ac_q <= alu_to_ac_d;
      zero_q      <= zero_d;
    end
  end

  assign alu_out   = alu_out_q;
  assign alu_to_ac = alu_to_ac_q;
  assign zero      = zero_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module  : tb_seq_alu
// Purpose : Directed self-checking bench for seq_alu.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [23:0] a_in;
  logic [23:0] b_in;
  logic [23:0] alu_out;
  logic        alu_to_ac;
  logic        busy;
  logic        zero;

  int errors;
  int checks;

  seq_alu #(.WORD_SIZE(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .alu_out   (alu_out),
    .alu_to_ac (alu_to_ac),
    .busy      (busy),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly the next edge (E0), leaving start low after.
  task automatic issue(input logic [1:0] o, input logic [23:0] a, input logic [23:0] b);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    op    = 2'b01;
    a_in  = 24'd5;
    b_in  = 24'd5;
    repeat (2) step();
    checks++; if (alu_out !== 24'd0) begin errors++; $display("FAIL reset_out: got %0h expected 0", alu_out); end
    checks++; if (alu_to_ac !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", alu_to_ac); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
    start = 1'b0;
    rst   = 1'b1;
    step();
  endtask

  task automatic test_add();
    issue(2'b01, 24'd20, 24'd43);
    checks++; if (alu_out !== 24'd63) begin errors++; $display("FAIL add_out: got %0d expected 63", alu_out); end
    checks++; if (alu_to_ac !== 1'b1) begin errors++; $display("FAIL add_strobe: got %b expected 1", alu_to_ac); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy: got %b expected 0", busy); end
    step();
    checks++; if (alu_to_ac !== 1'b0) begin errors++; $display("FAIL add_strobe_end: got %b expected 0", alu_to_ac); end
    checks++; if (alu_out !== 24'd63) begin errors++; $display("FAIL add_hold: got %0d expected 63", alu_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy2: got %b expected 0", busy); end
  endtask

  task automatic test_sub_wrap();
    issue(2'b10, 24'd5, 24'd7);
    checks++; if (alu_out !== 24'hFFFFFE) begin errors++; $display("FAIL sub_wrap_out: got %0h expected fffffe", alu_out); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL sub_wrap_zero: got %b expected 0", zero); end
    step();
  endtask

  task automatic test_sub_zero();
    issue(2'b10, 24'd9, 24'd9);
    checks++; if (alu_out !== 24'd0) begin errors++; $display("FAIL sub_zero_out: got %0h expected 0", alu_out); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero_flag: got %b expected 1", zero); end
    step();
  endtask

  task automatic test_pass();
    issue(2'b00, 24'd123, 24'hABCDEF);
    checks++; if (alu_out !== 24'hABCDEF) begin errors++; $display("FAIL pass_out: got %0h expected abcdef", alu_out); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL pass_zero: got %b expected 0", zero); end
    step();
  endtask

  task automatic test_back_to_back();
    op    = 2'b01;
    a_in  = 24'd100;
    b_in  = 24'd200;
    start = 1'b1;
    step();
    checks++; if (alu_out !== 24'd300) begin errors++; $display("FAIL b2b_add: got %0d expected 300", alu_out); end
    checks++; if (alu_to_ac !== 1'b1) begin errors++; $display("FAIL b2b_strobe1: got %b expected 1", alu_to_ac); end
    op   = 2'b10;
    a_in = 24'd1000;
    b_in = 24'd1;
    step();
    checks++; if (alu_out !== 24'd999) begin errors++; $display("FAIL b2b_sub: got %0d expected 999", alu_out); end
    checks++; if (alu_to_ac !== 1'b1) begin errors++; $display("FAIL b2b_strobe2: got %b expected 1", alu_to_ac); end
    start = 1'b0;
    step();
    checks++; if (alu_to_ac !== 1'b0) begin errors++; $display("FAIL b2b_strobe_end: got %b expected 0", alu_to_ac); end
  endtask

  task automatic test_mul_basic();
    int busy_cnt;
    int pulses;
    int pulse_at;
    issue(2'b11, 24'd8, 24'd8);
    // Operands change after acceptance; a re-pulsed ADD must be ignored.
    a_in     = 24'd77;
    b_in     = 24'd99;
    busy_cnt = busy ? 1 : 0;
    pulses   = 0;
    pulse_at = -1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 10) begin
        start = 1'b1;
        op    = 2'b01;
      end else begin
        start = 1'b0;
      end
      step();
      if (busy) busy_cnt++;
      if (alu_to_ac) begin
        pulses++;
        pulse_at = i;
      end
    end
    start = 1'b0;
    checks++; if (busy_cnt != 25) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 25", busy_cnt); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL mul_pulse_count: got %0d expected 1", pulses); end
    checks++; if (pulse_at != 25) begin errors++; $display("FAIL mul_pulse_cycle: got %0d expected 25", pulse_at); end
    checks++; if (alu_out !== 24'd64) begin errors++; $display("FAIL mul_out: got %0d expected 64", alu_out); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL mul_zero: got %b expected 0", zero); end
  endtask

  task automatic test_mul_overflow();
    logic [23:0] exp_out;
    logic        exp_zero;
`ifdef SEQ_ALU_MUL_SAT_EN
    exp_out  = 24'hFFFFFF;
    exp_zero = 1'b0;
`else
    exp_out  = 24'h000000;
    exp_zero = 1'b1;
`endif
    issue(2'b11, 24'h001000, 24'h001000);
    repeat (25) step();
    checks++; if (alu_to_ac !== 1'b1) begin errors++; $display("FAIL ovf_strobe: got %b expected 1", alu_to_ac); end
    checks++; if (alu_out !== exp_out) begin errors++; $display("FAIL ovf_out: got %0h expected %0h", alu_out, exp_out); end
    checks++; if (zero !== exp_zero) begin errors++; $display("FAIL ovf_zero: got %b expected %b", zero, exp_zero); end
    step();
  endtask

  task automatic test_mul_large();
    issue(2'b11, 24'h000FFF, 24'h000FFF);
    repeat (24) step();
    checks++; if (alu_to_ac !== 1'b0) begin errors++; $display("FAIL large_early: got %b expected 0", alu_to_ac); end
    step();
    checks++; if (alu_out !== 24'hFFE001) begin errors++; $display("FAIL large_out: got %0h expected ffe001", alu_out); end
    checks++; if (alu_to_ac !== 1'b1) begin errors++; $display("FAIL large_strobe: got %b expected 1", alu_to_ac); end
    step();
    checks++; if (alu_to_ac !== 1'b0) begin errors++; $display("FAIL large_strobe_end: got %b expected 0", alu_to_ac); end
  endtask

  task automatic test_reset_mid_mul();
    int pulses;
    issue(2'b11, 24'd3, 24'd5);
    for (int i = 1; i <= 11; i++) step();
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (alu_out !== 24'd0) begin errors++; $display("FAIL midrst_out: got %0h expected 0", alu_out); end
    checks++; if (alu_to_ac !== 1'b0) begin errors++; $display("FAIL midrst_strobe: got %b expected 0", alu_to_ac); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL midrst_zero: got %b expected 0", zero); end
    rst    = 1'b1;
    pulses = 0;
    repeat (30) begin
      step();
      if (alu_to_ac) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", pulses); end
    issue(2'b01, 24'd1, 24'd1);
    checks++; if (alu_out !== 24'd2) begin errors++; $display("FAIL midrst_add: got %0d expected 2", alu_out); end
    checks++; if (alu_to_ac !== 1'b1) begin errors++; $display("FAIL midrst_add_strobe: got %b expected 1", alu_to_ac); end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a_in   = '0;
    b_in   = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_sub_zero();
    test_pass();
    test_back_to_back();
    test_mul_basic();
    test_mul_overflow();
    test_mul_large();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Multi-cycle arithmetic unit for the 24-bit matrix-multiplication datapath. Sits directly upstream of the accumulator register: consumes the accumulator output and a bus operand, and produces the `alu_out` word and the one-cycle `alu_to_ac` load strobe that the accumulator uses to capture results. Add, subtract and pass complete in one cycle. Multiply is an iterative shift-add taking WORD_SIZE cycles.

## Interface
- `WORD_SIZE`, default 24: datapath width in bits; applies to operands, result and the multiply iteration count.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  operation code: 00 PASS_B, 01 ADD, 10 SUB, 11 MUL.
- `a_in`  in  WORD_SIZE  operand A (accumulator output).
- `b_in`  in  WORD_SIZE  operand B (data bus).
- `alu_out`  out  WORD_SIZE  registered result; holds its value between operations.
- `alu_to_ac`  out  1  single-cycle strobe; `alu_out` is valid while it is high.
- `busy`  out  1  high while an accepted operation has not yet delivered its result.
- `zero`  out  1  registered flag: `alu_out` == 0, updated together with `alu_out`.

## Operation
- **Reset** (`rst`=0 at an edge):
  - `alu_out`=0, `alu_to_ac`=0, `busy`=0, `zero`=0.
  - State goes to IDLE; internal multiplicand, multiplier, accumulator and counter are cleared.
  - Reset has priority over every other input.
- **States:** IDLE, MUL, DONE.
- **IDLE**, `start`=1: `a_in`, `b_in` and `op` are latched at that edge.
  - PASS_B, ADD, SUB: result written to `alu_out` at the same edge. `alu_to_ac` is high for the following cycle. State stays IDLE.
  - MUL: go to MUL with count=0, product accumulator=0, multiplicand=`a_in`, multiplier=`b_in`.
- **IDLE**, `start`=0: `alu_to_ac` returns low; `alu_out` holds.
- **MUL**, each edge:
  - If multiplier bit 0 is 1, add the multiplicand to the product accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1; increment the count.
  - After WORD_SIZE iterations, go to DONE.
- **DONE:** load `alu_out` with the final product (see Configuration), update `zero`, raise `alu_to_ac` for one cycle, return to IDLE.
- `start` is ignored while the state is MUL or DONE. It is not queued.
- **Arithmetic:**
  - ADD and SUB are unsigned, modulo 2^WORD_SIZE. Carry and borrow are discarded.
  - The MUL product accumulator is 2×WORD_SIZE bits wide; the operands are unsigned.
- Operand changes after the accepting edge have no effect on the operation in flight.

## Timing
- Edge E0 is the edge that accepts `start`.
- PASS/ADD/SUB:
  - `alu_out` is updated at E0.
  - `alu_to_ac`=1 in the cycle between E0 and E1.
  - `busy` stays 0.
  - Back-to-back single-cycle operations on consecutive edges are allowed; `alu_to_ac` then stays high continuously.
- MUL:
  - `busy`=1 from E0 until E(WORD_SIZE+1).
  - Result is loaded at E(WORD_SIZE+1); `alu_to_ac`=1 for exactly the following cycle. For WORD_SIZE=24, that is a 25-cycle latency.
  - The next `start` can be accepted at E(WORD_SIZE+2) at the earliest.
- `alu_to_ac` is never high for two cycles from a single MUL.
- Reset mid-MUL:
  - The operation is aborted; no `alu_to_ac` pulse is produced.
  - `alu_out`=0 after the reset edge.

## Configuration
- Macro: `SEQ_ALU_MUL_SAT_EN`.
- **Defined:** if the upper WORD_SIZE bits of the MUL product are non-zero, `alu_out` = all ones (0xFFFFFF) and `zero`=0.
- **Undefined:** `alu_out` = low WORD_SIZE bits of the product (truncation); `zero` reflects the truncated value.
- PASS, ADD and SUB are unaffected in both builds.

## Test plan
- **Reset:** hold `rst`=0 for 2 edges with `start`=1 → `alu_out`=0, `alu_to_ac`=0, `busy`=0, `zero`=0.
- **ADD:** `a_in`=20, `b_in`=43, `op`=01, `start` pulsed for 1 cycle → `alu_out`=63 and `alu_to_ac`=1 in the next cycle only; `busy` never rises.
- **SUB wrap:** `a_in`=5, `b_in`=7, `op`=10 → `alu_out`=0xFFFFFE, `zero`=0.
- **SUB to zero:** `a_in`=9, `b_in`=9 → `zero`=1.
- **MUL basic:** `a_in`=8, `b_in`=8, `op`=11, then `start` re-pulsed with `op`=01 at cycle 10 →
  - `busy` high for 25 cycles;
  - `alu_out`=64 with a single `alu_to_ac` pulse at cycle 25;
  - the re-pulsed `start` is ignored (no extra pulse, `alu_out` stays 64).
- **MUL overflow:** `a_in`=0x001000, `b_in`=0x001000 →
  - without the macro: `alu_out`=0x000000, `zero`=1;
  - with `SEQ_ALU_MUL_SAT_EN`: `alu_out`=0xFFFFFF, `zero`=0.
- **Reset mid-MUL:** start 3×5, drive `rst`=0 at cycle 12 → no `alu_to_ac` pulse, `busy`=0 and `alu_out`=0 after that edge; a new ADD 1+1 afterwards yields 2 one cycle after its start.
